// File: rtl/ct_sched.sv
// ct_sched: round-robin scheduler that shares one loadable up-counter among
// N requesters. The winner's delay is loaded as ~len, the counter runs until
// terminal count (or abort), then the owner receives a one-cycle done pulse.
// All state changes on the falling edge of clk_l.
module ct_sched #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk_l,
  input  logic           reset_l,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] len,
  input  logic           abort,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           aborted,
  output logic           busy,
  output logic           ctr_reset,
  output logic           ctr_load,
  output logic           ctr_enable_l,
  output logic [W-1:0]   ctr_data,
  input  logic [W-1:0]   ctr_count,
  input  logic           ctr_carry
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]    state_r;
  logic [IW-1:0] owner_r;
  logic [IW-1:0] ptr_r;
  logic [W-1:0]  len_r;
  logic          aborted_r;

  logic          any_req_s;
  logic [IW-1:0] pick_idx_s;
  logic [IW-1:0] ptr_next_s;
  logic          term_s;
  logic [N-1:0]  owner_oh_s;

  // Terminal count is taken from carry, with the all-ones count as a redundant
  // detector so a stuck-low carry line cannot leave the job running forever.
  assign term_s = ctr_carry | (&ctr_count);

  // Pointer advances past the owner that just finished, wrapping N-1 -> 0.
  assign ptr_next_s = (owner_r == IW'(N - 1)) ? {IW{1'b0}} : (owner_r + IW'(1));

  assign owner_oh_s = {{(N-1){1'b0}}, 1'b1} << owner_r;

  // Round-robin pick: scanning from the highest offset down lets the closest
  // pending requester at or after the pointer win.
  always_comb begin
    any_req_s  = 1'b0;
    pick_idx_s = {IW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      any_req_s  = any_req_s | req[(int'(ptr_r) + k) % N];
      pick_idx_s = req[(int'(ptr_r) + k) % N] ? IW'((int'(ptr_r) + k) % N) : pick_idx_s;
    end
  end

  // Controller state, owner/length capture and round-robin pointer.
  always_ff @(negedge clk_l) begin
    if (!reset_l) begin
      state_r   <= ST_IDLE;
      owner_r   <= {IW{1'b0}};
      ptr_r     <= {IW{1'b0}};
      len_r     <= {W{1'b0}};
      aborted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            owner_r   <= pick_idx_s;
            len_r     <= len[int'(pick_idx_s) * W +: W];
            aborted_r <= 1'b0;
            state_r   <= ST_LOAD;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          // Carry wins over a coincident abort: the job completed normally.
          if (term_s) begin
            aborted_r <= 1'b0;
            state_r   <= ST_DONE;
          end else if (abort) begin
            aborted_r <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            state_r   <= ST_RUN;
          end
        end
        ST_DONE: begin
          ptr_r     <= ptr_next_s;
          aborted_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          aborted_r <= 1'b0;
        end
      endcase
    end
  end

  // Moore decode of grant/status and counter controls; enable follows carry in RUN.
  always_comb begin
    grant        = {N{1'b0}};
    done         = {N{1'b0}};
    aborted      = 1'b0;
    busy         = 1'b0;
    ctr_load     = 1'b0;
    ctr_data     = {W{1'b0}};
    ctr_enable_l = 1'b1;
    ctr_reset    = !reset_l;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_LOAD: begin
        grant    = owner_oh_s;
        busy     = 1'b1;
        ctr_load = 1'b1;
        ctr_data = ~len_r;
      end
      ST_RUN: begin
        grant        = owner_oh_s;
        busy         = 1'b1;
        ctr_enable_l = term_s;
      end
      ST_DONE: begin
        grant     = owner_oh_s;
        done      = owner_oh_s;
        aborted   = aborted_r;
        busy      = 1'b1;
        ctr_reset = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ct_sched.sv
// Bench for ct_sched: a behavioural loadable up-counter closes the loop, a
// table of single jobs plus hand-written sequences drive the scheduler, and a
// scoreboard of expected completions is checked as done pulses appear.
module tb_ct_sched;

  logic        clk_l;
  logic        reset_l;
  logic [3:0]  req;
  logic [31:0] len;
  logic        abort;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        aborted;
  logic        busy;
  logic        ctr_reset;
  logic        ctr_load;
  logic        ctr_enable_l;
  logic [7:0]  ctr_data;
  logic [7:0]  ctr_count;
  logic        ctr_carry;

  ct_sched #(.N(4), .W(8)) dut (
    .clk_l(clk_l), .reset_l(reset_l), .req(req), .len(len), .abort(abort),
    .grant(grant), .done(done), .aborted(aborted), .busy(busy),
    .ctr_reset(ctr_reset), .ctr_load(ctr_load), .ctr_enable_l(ctr_enable_l),
    .ctr_data(ctr_data), .ctr_count(ctr_count), .ctr_carry(ctr_carry)
  );

  initial begin
    clk_l = 1'b1;
    forever #5 clk_l = ~clk_l;
  end

  // Shared ct8-style counter: sync reset, then load, then count when enabled.
  always @(negedge clk_l) begin
    if (ctr_reset) ctr_count <= 8'h00;
    else if (ctr_load) ctr_count <= ctr_data;
    else if (!ctr_enable_l) ctr_count <= ctr_count + 8'h01;
  end
  assign ctr_carry = (ctr_count == 8'hFF);

  typedef struct {
    logic [3:0] done_v;
    logic       ab;
    int         cyc;
    logic [7:0] data;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] len;
    int          abort_at;
    logic [3:0]  exp_done;
    logic        exp_ab;
    int          exp_cyc;
    logic [7:0]  exp_data;
    logic [7:0]  exp_cnt;
  } vec_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         ndone   = 0;
  int         cyc     = 0;
  int         gap     = 0;
  bit         chk_gap = 1'b0;
  bit         have_prev = 1'b0;
  logic [3:0] prev_grant = 4'b0000;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] d, input logic a, input int c,
                              input logic [7:0] dat, input logic [7:0] cn);
    exp_t e;
    e.done_v = d; e.ab = a; e.cyc = c; e.data = dat; e.cnt = cn;
    return e;
  endfunction

  // One clock of observation on the rising edge, half a cycle from the active edge.
  task automatic step();
    exp_t e;
    logic inv;
    @(posedge clk_l);
    inv = $onehot0(grant) && ((done & ~grant) == 4'b0000) &&
          (busy == (grant != 4'b0000)) &&
          (ctr_reset == ((done != 4'b0000) || !reset_l)) &&
          (!aborted || (done != 4'b0000)) &&
          (ctr_enable_l || (busy && !ctr_load && !ctr_reset)) &&
          (ctr_load || (ctr_data == 8'h00));
    chk("invariant", 64'(inv), 64'd1);
    if (grant != 4'b0000 && prev_grant == 4'b0000) begin
      cyc = 1;
      if (chk_gap && have_prev) chk("idle_gap", 64'(gap), 64'd1);
      gap = 0;
      have_prev = 1'b1;
      if (sb.size() == 0) chk("unexpected_grant", 64'(grant), 64'd0);
      else begin
        chk("grant_owner", 64'(grant), 64'(sb[0].done_v));
        chk("load_data", 64'({ctr_load, ctr_enable_l, ctr_data}), 64'({1'b1, 1'b1, sb[0].data}));
      end
    end else if (grant != 4'b0000) begin
      cyc++;
    end else begin
      cyc = 0;
      gap++;
    end
    if (done != 4'b0000) begin
      if (sb.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
      else begin
        e = sb.pop_front();
        chk("done_owner", 64'(done), 64'(e.done_v));
        chk("aborted", 64'(aborted), 64'(e.ab));
        chk("grant_cycles", 64'(cyc), 64'(e.cyc));
        chk("count_at_done", 64'(ctr_count), 64'(e.cnt));
      end
      ndone++;
    end
    prev_grant = grant;
  endtask

  // Observe until tgt jobs have completed, bounded by budget cycles.
  task automatic run_done(input int tgt, input int budget);
    for (int i = 0; i < budget && ndone < tgt; i++) step();
    chk("jobs_completed", 64'(ndone), 64'(tgt));
  endtask

  vec_t vt[9];
  int   tgt;

  initial begin
    // len fields are {len3, len2, len1, len0}
    vt[0] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd5},     -1, 4'b0001, 1'b0, 8,   8'hFA, 8'hFF};
    vt[1] = '{4'b0100, {8'd9, 8'd0, 8'd7, 8'd6},     -1, 4'b0100, 1'b0, 3,   8'hFF, 8'hFF};
    vt[2] = '{4'b0011, {8'd0, 8'd0, 8'd50, 8'd1},     0, 4'b0001, 1'b0, 4,   8'hFE, 8'hFF};
    vt[3] = '{4'b1001, {8'd7, 8'd0, 8'd0, 8'd30},    -1, 4'b1000, 1'b0, 10,  8'hF8, 8'hFF};
    vt[4] = '{4'b0010, {8'd0, 8'd0, 8'd200, 8'd0},   11, 4'b0010, 1'b1, 12,  8'h37, 8'h41};
    vt[5] = '{4'b1100, {8'd9, 8'd3, 8'd0, 8'd0},     -1, 4'b0100, 1'b0, 6,   8'hFC, 8'hFF};
    vt[6] = '{4'b0100, {8'd0, 8'd4, 8'd0, 8'd0},      1, 4'b0100, 1'b0, 7,   8'hFB, 8'hFF};
    vt[7] = '{4'b1000, {8'd2, 8'd0, 8'd0, 8'd0},      4, 4'b1000, 1'b0, 5,   8'hFD, 8'hFF};
    vt[8] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd255},   -1, 4'b0001, 1'b0, 258, 8'h00, 8'hFF};

    // Reset held for two edges
    reset_l = 1'b0; req = 4'b0000; len = 32'd0; abort = 1'b0;
    step(); step();
    chk("reset_state", 64'({grant, done, aborted, busy, ctr_reset}), 64'({4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1}));
    reset_l = 1'b1;
    step();
    chk("reset_release", 64'({busy, ctr_reset, ctr_load}), 64'd0);

    // Round robin over all four requesters, len=2 each
    req = 4'b1111; len = {8'd2, 8'd2, 8'd2, 8'd2};
    chk_gap = 1'b1; have_prev = 1'b0;
    sb.push_back(mk(4'b0001, 1'b0, 5, 8'hFD, 8'hFF));
    sb.push_back(mk(4'b0010, 1'b0, 5, 8'hFD, 8'hFF));
    sb.push_back(mk(4'b0100, 1'b0, 5, 8'hFD, 8'hFF));
    sb.push_back(mk(4'b1000, 1'b0, 5, 8'hFD, 8'hFF));
    sb.push_back(mk(4'b0001, 1'b0, 5, 8'hFD, 8'hFF));
    run_done(ndone + 5, 60);
    req = 4'b0000;
    chk_gap = 1'b0;

    // Single-job table
    for (int v = 0; v < 9; v++) begin
      req = vt[v].req; len = vt[v].len; abort = 1'b0;
      sb.push_back(mk(vt[v].exp_done, vt[v].exp_ab, vt[v].exp_cyc, vt[v].exp_data, vt[v].exp_cnt));
      tgt = ndone + 1;
      for (int i = 0; i < 400 && ndone < tgt; i++) begin
        step();
        if (cyc == 1) begin
          req = 4'b0000;
          len = $urandom;
        end
        abort = (cyc == vt[v].abort_at);
      end
      abort = 1'b0;
      chk("vec_done", 64'(ndone), 64'(tgt));
    end

    // Lone requester keeps requesting: re-granted back to back
    req = 4'b0001; len = {8'd1, 8'd1, 8'd1, 8'd1};
    sb.push_back(mk(4'b0001, 1'b0, 4, 8'hFE, 8'hFF));
    sb.push_back(mk(4'b0001, 1'b0, 4, 8'hFE, 8'hFF));
    run_done(ndone + 2, 30);
    req = 4'b0000;

    // Two persistent requesters alternate
    req = 4'b0011;
    sb.push_back(mk(4'b0010, 1'b0, 4, 8'hFE, 8'hFF));
    sb.push_back(mk(4'b0001, 1'b0, 4, 8'hFE, 8'hFF));
    sb.push_back(mk(4'b0010, 1'b0, 4, 8'hFE, 8'hFF));
    run_done(ndone + 3, 40);
    req = 4'b0000;

    // Reset in the middle of RUN drops the job and rewinds the pointer
    step();
    req = 4'b0100; len = {8'd0, 8'd100, 8'd0, 8'd0};
    sb.push_back(mk(4'b0100, 1'b0, 0, 8'h9B, 8'hFF));
    for (int i = 0; i < 20 && cyc != 5; i++) step();
    chk("reached_run", 64'(cyc), 64'd5);
    reset_l = 1'b0; req = 4'b0000;
    void'(sb.pop_front());
    step();
    chk("mid_reset", 64'({grant, done, busy, ctr_reset}), 64'({4'b0000, 4'b0000, 1'b0, 1'b1}));
    reset_l = 1'b1;
    req = 4'b0101; len = {8'd0, 8'd1, 8'd0, 8'd1};
    sb.push_back(mk(4'b0001, 1'b0, 4, 8'hFE, 8'hFF));
    sb.push_back(mk(4'b0100, 1'b0, 4, 8'hFE, 8'hFF));
    run_done(ndone + 2, 30);
    req = 4'b0000;

    step(); step(); step();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
